// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN top-level scheduler.
package gcn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_F,
    COMB,
    AGG,
    ARGMAX,
    DONE
  } gcn_state_t;

  localparam int FEATURE_BASE = 512;

endpackage

// File: rtl/gcn_step_counter.sv
// Saturating up-counter: synchronous clear, enable, and a flag at LIMIT-1.
module gcn_step_counter
  import gcn_pkg::*;
#(
  parameter int LIMIT = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);

  assign term = (count == W'(LIMIT - 1));

  // Holds at the terminal value so an index never wraps past its range
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (clear)          count <= '0;
    else if (en && !term)    count <= count + 1'b1;
  end

endmodule

// File: rtl/gcn_scheduler.sv
// Top-level GCN sequencer: weight/feature fetch, per-row combination,
// COO aggregation walk, argmax sweep, then done.
module gcn_scheduler #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int COO_NUM_OF_COLS       = 6,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int FEATURE_BASE          = gcn_pkg::FEATURE_BASE,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COO_BW                = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             comb_done,
  output logic                             enable_read,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             wgt_load,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  wgt_col,
  output logic                             fm_load,
  output logic [COUNTER_FEATURE_WIDTH-1:0] fm_row,
  output logic                             comb_start,
  output logic [COO_BW-1:0]                coo_address,
  output logic                             agg_valid,
  output logic                             argmax_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0] argmax_row,
  output logic                             done
);

  import gcn_pkg::*;

  gcn_state_t state;
  logic       comb_first;

  logic [COUNTER_WEIGHT_WIDTH-1:0]  w_cnt;
  logic [COUNTER_FEATURE_WIDTH-1:0] f_cnt;
  logic [COO_BW-1:0]                c_cnt;
  logic [COUNTER_FEATURE_WIDTH-1:0] r_cnt;
  logic w_term, f_term, c_term, r_term;
  logic row_finished;

  // comb_done is only honoured after the comb_start cycle
  assign row_finished = (state == COMB) && !comb_first && comb_done;

  gcn_step_counter #(.LIMIT(WEIGHT_COLS), .W(COUNTER_WEIGHT_WIDTH)) u_w_cnt (
    .clk(clk), .reset(reset),
    .clear(state == IDLE && start), .en(state == LOAD_W),
    .count(w_cnt), .term(w_term)
  );

  gcn_step_counter #(.LIMIT(FEATURE_ROWS), .W(COUNTER_FEATURE_WIDTH)) u_f_cnt (
    .clk(clk), .reset(reset),
    .clear(state == LOAD_W && w_term), .en(row_finished),
    .count(f_cnt), .term(f_term)
  );

  gcn_step_counter #(.LIMIT(COO_NUM_OF_COLS), .W(COO_BW)) u_c_cnt (
    .clk(clk), .reset(reset),
    .clear(row_finished && f_term), .en(state == AGG),
    .count(c_cnt), .term(c_term)
  );

  gcn_step_counter #(.LIMIT(FEATURE_ROWS), .W(COUNTER_FEATURE_WIDTH)) u_r_cnt (
    .clk(clk), .reset(reset),
    .clear(state == AGG && c_term), .en(state == ARGMAX),
    .count(r_cnt), .term(r_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      comb_first <= 1'b0;
    end else begin
      comb_first <= 1'b0;
      case (state)
        IDLE:   if (start) state <= LOAD_W;
        LOAD_W: if (w_term) state <= LOAD_F;
        LOAD_F: begin
          state      <= COMB;
          comb_first <= 1'b1;
        end
        COMB:   if (row_finished) state <= f_term ? AGG : LOAD_F;
        AGG:    if (c_term) state <= ARGMAX;
        ARGMAX: if (r_term) state <= DONE;
        DONE:   if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_address = '0;
    if (state == LOAD_W)
      read_address = ADDRESS_WIDTH'(w_cnt);
    else if (state == LOAD_F)
      read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(f_cnt);
  end

  assign enable_read = (state == LOAD_W) || (state == LOAD_F);
  assign wgt_load    = (state == LOAD_W);
  assign wgt_col     = w_cnt;
  assign fm_load     = (state == LOAD_F);
  assign fm_row      = f_cnt;
  assign comb_start  = comb_first;
  assign agg_valid   = (state == AGG);
  assign coo_address = (state == AGG) ? c_cnt : '0;
  assign argmax_en   = (state == ARGMAX);
  assign argmax_row  = r_cnt;
  assign done        = (state == DONE);

endmodule
